// File: rtl/avr_uart_rx.sv
// 8N1 serial receiver for the AVR link: synchronizer, start-glitch / framing
// checks, and a small FIFO presenting bytes through a valid/ready interface.
module avr_uart_rx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int HALF  = CLK_PER_BIT / 2;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HI
  } state_t;

  state_t              r_state;
  logic                r_sync1, r_rx_s;
  logic [CW-1:0]       r_clk_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;

  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_count;

  logic w_tick_half, w_tick_bit, w_stop_smp, w_push, w_pop, w_full, w_wr;

  // Two-flop synchronizer; idles high so reset doesn't look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_tick_half = (r_clk_cnt == CW'(HALF - 1));
  assign w_tick_bit  = (r_clk_cnt == CW'(CLK_PER_BIT - 1));
  assign w_stop_smp  = (r_state == ST_STOP) && w_tick_bit && rx_en;
  assign w_push      = w_stop_smp && r_rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!rx_en && r_state != ST_IDLE) begin
        r_state   <= ST_IDLE;
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            if (!r_rx_s && rx_en) r_state <= ST_START;
          end
          ST_START: begin
            if (w_tick_half) begin
              r_clk_cnt <= '0;
              r_bit_cnt <= '0;
              r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
            end else begin
              r_clk_cnt <= r_clk_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (w_tick_bit) begin
              r_clk_cnt <= '0;
              r_shift   <= {r_rx_s, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= '0;
                r_state   <= ST_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_clk_cnt <= r_clk_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (w_tick_bit) begin
              r_clk_cnt <= '0;
              if (r_rx_s) begin
                r_state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= ST_WAIT_HI;
              end
            end else begin
              r_clk_cnt <= r_clk_cnt + 1'b1;
            end
          end
          ST_WAIT_HI: begin
            r_clk_cnt <= '0;
            if (r_rx_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // A full FIFO still takes the byte if the head leaves on the same edge.
  assign w_full = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_pop  = valid && ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign valid  = (r_count != '0);
  assign data   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_uart_rx.sv
// Directed bench for avr_uart_rx: serial frames driven bit by bit, expected
// bytes queued as sent and checked as they are popped.
module tb_avr_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n, rx_en, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ferr   = 0;
  int n_ovf    = 0;
  int n_pop    = 0;
  int n_vhigh  = 0;
  int t_vrise  = 0;
  logic prev_valid = 1'b0;
  logic [8:0] q[$];

  avr_uart_rx #(.CLK_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulses, valid-rise time, and scoreboard pops.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) n_ferr++;
      if (overflow)  n_ovf++;
      if (valid) n_vhigh++;
      if (valid && !prev_valid) t_vrise = cyc;
      prev_valid = valid;
      if (valid && ready) begin
        logic [8:0] e;
        e = (q.size() > 0) ? q.pop_front() : 9'h1FF;
        n_pop++;
        chk("pop_data", {23'd0, 1'b0, data}, {23'd0, e});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now; drop_at >= 0 removes rx_en at that data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int drop_at);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) rx_en = 1'b0;
      rx = b[i]; tick(CPB);
    end
    rx = stop; tick(CPB);
    if (drop_at >= 0) rx_en = 1'b1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q.size() > 0 || valid) && t < 400) begin
      tick(1); t++;
    end
    chk({tag, "_drain_timeout"}, int'(t >= 400), 0);
    chk({tag, "_q_empty"}, q.size(), 0);
    chk({tag, "_valid_low"}, int'(valid), 0);
  endtask

  initial begin
    int c0, ferr0, ovf0, pop0, vh0;
    rst_n = 1'b0; rx_en = 1'b0; rx = 1'b1; ready = 1'b0;
    tick(3);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1; rx_en = 1'b1; ready = 1'b1;
    tick(5);

    // Basic receive with latency measurement
    vh0 = n_vhigh; c0 = cyc;
    q.push_back(9'h0A5);
    send_byte(8'hA5, 1'b1, -1);
    tick(4);
    chk("basic_latency_ok", int'((t_vrise - c0) >= 78 && (t_vrise - c0) <= 80), 1);
    chk("basic_valid_cycles", n_vhigh - vh0, 1);
    chk("basic_no_ferr", n_ferr, 0);
    chk("basic_no_ovf", n_ovf, 0);
    drain("basic");

    // Back-to-back burst into a stalled consumer; 5th byte overflows
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) q.push_back(9'(i));
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, -1);
    tick(4);
    chk("ovf_pulses", n_ovf, 1);
    chk("ovf_valid", int'(valid), 1);
    chk("ovf_head", int'(data), 8'h01);
    ready = 1'b1;
    drain("ovf");

    // Framing error followed by a held-low break
    ferr0 = n_ferr; pop0 = n_pop;
    send_byte(8'h3C, 1'b0, -1);
    rx = 1'b0; tick(3*CPB);
    rx = 1'b1; tick(2*CPB);
    chk("ferr_pulses", n_ferr - ferr0, 1);
    chk("ferr_no_push", n_pop - pop0, 0);
    q.push_back(9'h07E);
    send_byte(8'h7E, 1'b1, -1);
    tick(4);
    drain("ferr_next");

    // Start-bit glitch
    ferr0 = n_ferr; pop0 = n_pop;
    rx = 1'b0; tick(2);
    rx = 1'b1; tick(2*CPB);
    chk("glitch_no_pop", n_pop - pop0, 0);
    chk("glitch_no_ferr", n_ferr - ferr0, 0);
    q.push_back(9'h0C3);
    send_byte(8'hC3, 1'b1, -1);
    tick(4);
    drain("glitch_next");

    // Gating: disabled for a full frame, then abort mid-frame
    pop0 = n_pop; ferr0 = n_ferr; ovf0 = n_ovf;
    rx_en = 1'b0;
    send_byte(8'h55, 1'b1, -1);
    tick(2*CPB);
    chk("gate_no_pop", n_pop - pop0, 0);
    chk("gate_valid", int'(valid), 0);
    rx_en = 1'b1; ready = 1'b0;
    q.push_back(9'h011);
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h99, 1'b1, 3);
    tick(2*CPB);
    chk("abort_valid", int'(valid), 1);
    chk("abort_head", int'(data), 8'h11);
    chk("abort_no_ferr", n_ferr - ferr0, 0);
    chk("abort_no_ovf", n_ovf - ovf0, 0);
    ready = 1'b1;
    drain("abort");

    // Full FIFO with a pop on the stop-bit sample edge of the 5th byte
    ready = 1'b0; ovf0 = n_ovf;
    for (int i = 0; i < 4; i++) begin
      q.push_back(9'(8'h10 + i));
      send_byte(8'(8'h10 + i), 1'b1, -1);
    end
    q.push_back(9'h014);
    fork
      send_byte(8'h14, 1'b1, -1);
      begin
        repeat (78) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    tick(4);
    chk("simul_no_ovf", n_ovf - ovf0, 0);
    chk("simul_valid", int'(valid), 1);
    chk("simul_head", int'(data), 8'h11);
    ready = 1'b1;
    drain("simul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
